bcd_addsub_serial: RTL and testbench

- Parametrised multi-digit BCD adder/subtractor; successor to the single-digit combinational BCD subtractor.
- Processes one BCD digit per clock, least-significant digit first, with a start/done handshake.
- Returns sign-magnitude results for subtraction, so no ten's-complement result ever leaves the block.
- Sits between the operand registers and the display/result path of the calculator datapath.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_addsub.sv | 35 +++
 rtl/bcd_addsub_serial.sv | 173 +++++++++++++++++
 tb/tb_bcd_addsub_serial.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the serial BCD add/subtract datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: FSM state encodings, BCD digit width and the largest legal BCD digit.
package bcd_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit adder/subtractor: s = a + (sub ? 9-b : b) + cin, decimal-corrected.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b - BCD digits; cin - decimal carry in; sub - use 9's complement of b;
//        s - BCD digit result; cout - decimal carry out.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] b_eff;
  logic [4:0] sum;
  logic [4:0] sum_adj;

  always_comb begin
    b_eff   = sub ? (BCD_MAX_DIGIT - b) : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
    sum_adj = sum + 5'd6;
    // A 5-bit sum above 9 covers both the >9 case and the 4-bit adder carry.
    if (sum > 5'd9) begin
      s    = sum_adj[3:0];
      cout = 1'b1;
    end else begin
      s    = sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Serial multi-digit BCD adder/subtractor, one digit per cycle LSD first, sign-magnitude result.
// Latency: START edge to DONE = DIGITS+1 (add, A>=B sub), 2*DIGITS+1 (A<B sub), 2 (invalid operand).
// Backpressure: START accepted only in IDLE outside the DONE pulse; START while BUSY is dropped.
// Ports: CLK, nRST (sync, active-low); START/OP/A/B request; BUSY, DONE, S, SIGN, COUT results.
// Build option BCD_VALID_CHECK_EN adds INVALID: any operand nibble > 9 aborts with a zero result.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          START,
  input  logic                          OP,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] A,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] B,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [BCD_DIGIT_W*DIGITS-1:0] S,
  output logic                          SIGN,
  output logic                          COUT
`ifdef BCD_VALID_CHECK_EN
  ,
  output logic                          INVALID
`endif
);

  localparam int         W    = BCD_DIGIT_W * DIGITS;
  localparam logic [4:0] LAST = 5'(DIGITS - 1);

  logic [1:0]   state;
  logic [4:0]   cnt;
  logic         carry;
  logic         op_q;
  logic [W-1:0] a_sh;
  logic [W-1:0] b_sh;

  logic [3:0]   dig_a;
  logic [3:0]   dig_b;
  logic         dig_sub;
  logic [3:0]   dig_s;
  logic         dig_cout;
  logic [W-1:0] s_next;
  logic         last;

  // RUN feeds the operand digits; FIX negates the ten's-complement result
  // already sitting in S by computing 0 - digit with the running borrow.
  always_comb begin
    if (state == ST_FIX) begin
      dig_a   = 4'd0;
      dig_b   = S[3:0];
      dig_sub = 1'b1;
    end else begin
      dig_a   = a_sh[3:0];
      dig_b   = b_sh[3:0];
      dig_sub = op_q;
    end
    // Result digits enter at the top so after DIGITS shifts digit 0 is at the bottom.
    s_next                       = S >> BCD_DIGIT_W;
    s_next[W-1 -: BCD_DIGIT_W]   = dig_s;
    last                         = (cnt == LAST);
  end

  bcd_digit_addsub u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .sub  (dig_sub),
    .s    (dig_s),
    .cout (dig_cout)
  );

`ifdef BCD_VALID_CHECK_EN
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      op_q  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      S     <= '0;
      SIGN  <= 1'b0;
      COUT  <= 1'b0;
`ifdef BCD_VALID_CHECK_EN
      INVALID <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          // DONE is still high in the first IDLE cycle; a START there is dropped.
          if (START && !DONE) begin
            a_sh  <= A;
            b_sh  <= B;
            op_q  <= OP;
            carry <= OP;  // +1 of the ten's complement
            cnt   <= '0;
            S     <= '0;
            SIGN  <= 1'b0;
            COUT  <= 1'b0;
            BUSY  <= 1'b1;
            state <= ST_RUN;
`ifdef BCD_VALID_CHECK_EN
            INVALID <= has_bad_digit(A) || has_bad_digit(B);
`endif
          end
        end

        ST_RUN: begin
`ifdef BCD_VALID_CHECK_EN
          if (INVALID) begin
            // Bad operand: spend this cycle idle so DONE lands two cycles after START.
            state <= ST_DONE;
          end else begin
`else
          begin
`endif
            a_sh  <= a_sh >> BCD_DIGIT_W;
            b_sh  <= b_sh >> BCD_DIGIT_W;
            S     <= s_next;
            carry <= dig_cout;
            cnt   <= cnt + 5'd1;
            if (last) begin
              cnt <= '0;
              if (!op_q) begin
                COUT  <= dig_cout;
                state <= ST_DONE;
              end else if (dig_cout) begin
                state <= ST_DONE;  // no final borrow: A >= B, result already magnitude
              end else begin
                carry <= 1'b1;     // A < B: negate S in a second pass
                state <= ST_FIX;
              end
            end
          end
        end

        ST_FIX: begin
          S     <= s_next;
          carry <= dig_cout;
          cnt   <= cnt + 5'd1;
          if (last) begin
            cnt   <= '0;
            SIGN  <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial: directed cases plus random add/sub against an
// integer-arithmetic reference model; checks latency, results, handshake and reset behaviour.
// Build option BCD_VALID_CHECK_EN also exercises the INVALID path.
module tb_bcd_addsub_serial;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         START;
  logic         OP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] S;
  logic         SIGN;
  logic         COUT;
`ifdef BCD_VALID_CHECK_EN
  logic         INVALID;
`endif

  int checks = 0;
  int errors = 0;

  bcd_addsub_serial #(.DIGITS(D)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .START (START),
    .OP    (OP),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .SIGN  (SIGN),
    .COUT  (COUT)
`ifdef BCD_VALID_CHECK_EN
    ,
    .INVALID (INVALID)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint n);
    logic [W-1:0] r = '0;
    longint       x = n;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Issue one request and check it. glitch_at > 0 pulses a 9999 START that many
  // cycles into the operation, which must be ignored.
  task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int glitch_at);
    longint       ai, bi, r;
    logic [W-1:0] e_s;
    logic         e_sign, e_cout;
    int           e_lat, n;

    ai = bcd2int(a);
    bi = bcd2int(b);
    e_sign = 1'b0;
    e_cout = 1'b0;
    e_lat  = D + 1;
    if (!op) begin
      r      = ai + bi;
      e_cout = (r >= pow10(D));
      e_s    = int2bcd(r % pow10(D));
    end else if (ai >= bi) begin
      e_s = int2bcd(ai - bi);
    end else begin
      e_s    = int2bcd(bi - ai);
      e_sign = 1'b1;
      e_lat  = 2 * D + 1;
    end

    @(negedge CLK);
    START = 1'b1;
    OP    = op;
    A     = a;
    B     = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    check({tag, ".busy_rise"}, 64'(BUSY), 64'(1'b1));

    n = 0;
    while (n < 100) begin
      @(posedge CLK);
      #1;
      n++;
      if (n == glitch_at) begin
        START = 1'b1;
        OP    = 1'b0;
        A     = 16'h9999;
        B     = 16'h9999;
      end else begin
        START = 1'b0;
      end
      if (DONE) break;
    end
    START = 1'b0;
    check({tag, ".latency"}, 64'(n), 64'(e_lat));
    check({tag, ".s"}, 64'(S), 64'(e_s));
    check({tag, ".sign"}, 64'(SIGN), 64'(e_sign));
    check({tag, ".cout"}, 64'(COUT), 64'(e_cout));
    check({tag, ".busy_at_done"}, 64'(BUSY), 64'(1'b0));
`ifdef BCD_VALID_CHECK_EN
    check({tag, ".invalid"}, 64'(INVALID), 64'(1'b0));
`endif

    // START during the DONE cycle must be dropped; results must hold.
    START = 1'b1;
    OP    = ~op;
    A     = 16'h9999;
    B     = 16'h0001;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check({tag, ".done_pulse"}, 64'(DONE), 64'(1'b0));
    check({tag, ".start_in_done_ignored"}, 64'(BUSY), 64'(1'b0));
    check({tag, ".s_hold"}, 64'(S), 64'(e_s));
    check({tag, ".sign_hold"}, 64'(SIGN), 64'(e_sign));
  endtask

  initial begin
    int           dones;
    logic         rop;
    logic [W-1:0] ra, rb;

    nRST  = 1'b0;
    START = 1'b0;
    OP    = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset.busy", 64'(BUSY), 64'(1'b0));
    check("reset.done", 64'(DONE), 64'(1'b0));
    check("reset.s", 64'(S), 64'(0));
    check("reset.sign", 64'(SIGN), 64'(1'b0));
    check("reset.cout", 64'(COUT), 64'(1'b0));
`ifdef BCD_VALID_CHECK_EN
    check("reset.invalid", 64'(INVALID), 64'(1'b0));
`endif
    @(negedge CLK);
    nRST = 1'b1;

    run_op("add_wrap_1234_8766", 1'b0, 16'h1234, 16'h8766, 0);
    run_op("sub_5000_1234", 1'b1, 16'h5000, 16'h1234, 0);
    run_op("sub_neg_1234_5000", 1'b1, 16'h1234, 16'h5000, 0);
    run_op("sub_neg_0000_0001", 1'b1, 16'h0000, 16'h0001, 0);
    run_op("sub_zero_0042_busy_start", 1'b1, 16'h0042, 16'h0042, 2);
    run_op("add_wrap_9999_0001", 1'b0, 16'h9999, 16'h0001, 0);
    run_op("sub_neg_busy_start", 1'b1, 16'h0000, 16'h9999, 6);

    // Reset in the middle of RUN.
    @(negedge CLK);
    START = 1'b1;
    OP    = 1'b0;
    A     = 16'h1234;
    B     = 16'h1111;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    check("midrun_reset.busy", 64'(BUSY), 64'(1'b0));
    check("midrun_reset.s", 64'(S), 64'(0));
    check("midrun_reset.done", 64'(DONE), 64'(1'b0));
    @(negedge CLK);
    nRST  = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge CLK);
      #1;
      if (DONE) dones++;
    end
    check("midrun_reset.no_done", 64'(dones), 64'(0));
    run_op("add_after_reset_0001_0009", 1'b0, 16'h0001, 16'h0009, 0);

`ifdef BCD_VALID_CHECK_EN
    begin
      int n;
      @(negedge CLK);
      START = 1'b1;
      OP    = 1'b0;
      A     = 16'h12A4;
      B     = 16'h0001;
      @(posedge CLK);
      #1;
      START = 1'b0;
      n = 0;
      while (n < 100) begin
        @(posedge CLK);
        #1;
        n++;
        if (DONE) break;
      end
      check("invalid.latency", 64'(n), 64'(2));
      check("invalid.flag", 64'(INVALID), 64'(1'b1));
      check("invalid.s", 64'(S), 64'(0));
      check("invalid.sign", 64'(SIGN), 64'(1'b0));
      check("invalid.cout", 64'(COUT), 64'(1'b0));
      @(posedge CLK);
      #1;
      run_op("valid_after_invalid", 1'b0, 16'h0005, 16'h0005, 0);
    end
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = rand_bcd();
      rb  = ($urandom_range(0, 7) == 0) ? ra : rand_bcd();
      run_op($sformatf("rand%0d", i), rop, ra, rb, ($urandom_range(0, 3) == 0) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the DUT wedges somewhere the bounded loops do not cover.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
